// File: rtl/lfsr_beacon_pkg.sv
// Shared LFSR constants and step function for the beacon transmit
// and receive-side polynomial finder.
package lfsr_beacon_pkg;

  localparam int LFSR_W     = 17;
  localparam int BIT_PERIOD = 16;

  localparam logic [LFSR_W-1:0] POLY_A = 17'h1D258;
  localparam logic [LFSR_W-1:0] POLY_B = 17'h17E04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FINISH
  } tx_state_e;

  // Fibonacci step: shift left, feedback is parity of tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] state,
    input logic [LFSR_W-1:0] poly
  );
    return {state[LFSR_W-2:0], ^(state & poly)};
  endfunction

endpackage

// File: rtl/bmc_encoder.sv
// Biphase-mark encoder: phase counter with a boundary toggle on
// every bit and a mid-bit toggle for ones.
module bmc_encoder #(
  parameter int BIT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_i,
  input  logic bit_valid_i,
  input  logic clear_i,
  output logic tx_out_o,
  output logic bit_end_o
);

  localparam int PW = $clog2(BIT_PERIOD);
  localparam logic [PW-1:0] PH_MID  = PW'(BIT_PERIOD / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_PERIOD - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      tx_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    tx_d    = tx_q;
    if (clear_i) begin
      phase_d = '0;
      tx_d    = 1'b0;
    end else if (bit_valid_i) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (phase_q == '0)
        tx_d = ~tx_q;
      else if (phase_q == PH_MID && bit_i)
        tx_d = ~tx_q;
    end
  end

  assign tx_out_o  = tx_q;
  assign bit_end_o = bit_valid_i && (phase_q == PH_LAST);

endmodule

// File: rtl/lfsr_beacon_tx.sv
// LFSR sweep beacon transmitter: seeds an LFSR and sends its
// output bit stream BMC-encoded, one bit per BIT_PERIOD clocks.
module lfsr_beacon_tx
  import lfsr_beacon_pkg::*;
#(
  parameter int          BIT_PERIOD = lfsr_beacon_pkg::BIT_PERIOD,
  parameter logic [16:0] POLY_A     = lfsr_beacon_pkg::POLY_A,
  parameter logic [16:0] POLY_B     = lfsr_beacon_pkg::POLY_B
) (
  input  logic        clk_96MHz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        poly_sel,
  input  logic [16:0] start_data,
  input  logic [16:0] burst_length,
  output logic        tx_out,
  output logic        tx_active,
  output logic        bit_strobe,
  output logic [16:0] value,
  output logic [16:0] iteration_number,
  output logic        done
);

  tx_state_e   state_q, state_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [16:0] iter_q, iter_d;
  logic [16:0] len_q, len_d;
  logic [16:0] poly_q, poly_d;

  logic send_act;
  logic enc_tx;
  logic bit_end;
  logic last_bit;
  logic accept;

  assign send_act = (state_q == ST_SEND) && !abort;
  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign last_bit = bit_end &&
                    (({1'b0, iter_q} + 18'd1) == {1'b0, len_q});

  bmc_encoder #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_enc (
    .clk        (clk_96MHz),
    .rst_n      (rst_n),
    .bit_i      (lfsr_q[16]),
    .bit_valid_i(send_act),
    .clear_i    (!send_act),
    .tx_out_o   (enc_tx),
    .bit_end_o  (bit_end)
  );

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      iter_q  <= '0;
      len_q   <= '0;
      poly_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      iter_q  <= iter_d;
      len_q   <= len_d;
      poly_q  <= poly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (start)
            state_d = (burst_length == '0) ? ST_FINISH : ST_SEND;
        ST_SEND:
          if (last_bit)
            state_d = ST_FINISH;
        ST_FINISH:
          state_d = ST_IDLE;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    iter_d = iter_q;
    len_d  = len_q;
    poly_d = poly_q;
    if (accept) begin
      lfsr_d = start_data;
      iter_d = '0;
      len_d  = burst_length;
      poly_d = poly_sel ? POLY_B : POLY_A;
    end else if (bit_end) begin
      lfsr_d = lfsr_next(lfsr_q, poly_q);
      iter_d = iter_q + 17'd1;
    end
  end

  always_comb begin
    tx_active        = (state_q == ST_SEND);
    tx_out           = enc_tx && (state_q == ST_SEND);
    bit_strobe       = bit_end;
    done             = (state_q == ST_FINISH) && !abort;
    value            = lfsr_q;
    iteration_number = iter_q;
  end

endmodule

// File: tb/tb_lfsr_beacon_tx.sv
// Self-checking bench for lfsr_beacon_tx: directed scenarios plus
// long random bursts decoded against a behavioural LFSR model.
module tb_lfsr_beacon_tx;
  import lfsr_beacon_pkg::*;

  localparam int BP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        poly_sel = 1'b0;
  logic [16:0] start_data = '0;
  logic [16:0] burst_length = '0;
  logic        tx_out, tx_active, bit_strobe, done;
  logic [16:0] value, iteration_number;

  int tests = 0;
  int fails = 0;

  lfsr_beacon_tx dut (
    .clk_96MHz       (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .poly_sel        (poly_sel),
    .start_data      (start_data),
    .burst_length    (burst_length),
    .tx_out          (tx_out),
    .tx_active       (tx_active),
    .bit_strobe      (bit_strobe),
    .value           (value),
    .iteration_number(iteration_number),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step: double the state modulo 2^17, add tap parity.
  function automatic logic [16:0] ref_step(input logic [16:0] s,
                                           input logic [16:0] p);
    int ones;
    int v;
    ones = $countones(s & p);
    v = (int'(s) * 2) % 131072 + (ones % 2);
    return 17'(v);
  endfunction

  task automatic launch(input logic [16:0] seed, input logic ps,
                        input logic [16:0] len);
    @(negedge clk);
    start_data   = seed;
    poly_sel     = ps;
    burst_length = len;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    start_data   = 17'($urandom);
    poly_sel     = ~ps;
    burst_length = 17'($urandom);
  endtask

  task automatic run_burst(input logic [16:0] seed, input logic ps,
                           input int len, input bit poke,
                           input string tag);
    logic [16:0] m;
    logic [16:0] p;
    logic        b;
    logic        exp_tx;
    logic        s1;
    logic        s9;
    int          t;
    m = seed;
    p = ps ? 17'h17E04 : 17'h1D258;
    exp_tx = 1'b0;
    s1 = 1'b0;
    s9 = 1'b0;
    t = 0;
    launch(seed, ps, len[16:0]);
    if (len == 0) begin
      chk({tag, ".done"}, done, 1);
      chk({tag, ".active"}, tx_active, 0);
      chk({tag, ".tx"}, tx_out, 0);
      chk({tag, ".iter"}, iteration_number, 0);
      @(negedge clk);
      chk({tag, ".done_off"}, done, 0);
      chk({tag, ".active2"}, tx_active, 0);
      return;
    end
    chk({tag, ".seed"}, value, seed);
    chk({tag, ".iter0"}, iteration_number, 0);
    for (int k = 0; k < len; k++) begin
      b = m[16];
      for (int ph = 0; ph < BP; ph++) begin
        chk({tag, ".active"}, tx_active, 1);
        chk({tag, ".tx"}, tx_out, exp_tx);
        chk({tag, ".strobe"}, bit_strobe, (ph == BP - 1));
        if (ph == 0 && k > 0)
          chk({tag, ".ts_iter"}, iteration_number, t / BP);
        if (ph == 1) s1 = tx_out;
        if (ph == BP / 2 + 1) s9 = tx_out;
        if (poke && k == 0 && ph == 3) start = 1'b1;
        if (poke && k == 0 && ph == 4) start = 1'b0;
        if (ph == 0) exp_tx = ~exp_tx;
        if (ph == BP / 2 && b) exp_tx = ~exp_tx;
        t++;
        @(negedge clk);
      end
      chk({tag, ".decode"}, s1 ^ s9, b);
      m = ref_step(m, p);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".fin_active"}, tx_active, 0);
    chk({tag, ".fin_tx"}, tx_out, 0);
    chk({tag, ".value"}, value, m);
    chk({tag, ".iter"}, iteration_number, len);
    @(negedge clk);
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".value_hold"}, value, m);
    chk({tag, ".iter_hold"}, iteration_number, len);
  endtask

  initial begin
    logic [16:0] seed;
    logic [16:0] m;
    logic        found;
    logic        saw_done;

    #1;
    chk("rst.tx", tx_out, 0);
    chk("rst.active", tx_active, 0);
    chk("rst.value", value, 0);
    chk("rst.iter", iteration_number, 0);
    chk("rst.done", done, 0);
    chk("rst.strobe", bit_strobe, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_burst(17'h00001, 1'b0, 3, 1'b0, "t1");
    run_burst(17'h18000, 1'b0, 1, 1'b0, "t2a");
    run_burst(17'h18000, 1'b1, 1, 1'b0, "t2b");
    run_burst(17'h00000, 1'b1, 2, 1'b0, "seed0");
    run_burst(17'h0ABCD, 1'b0, 0, 1'b0, "t3");

    seed = 17'($urandom);
    m = seed;
    launch(seed, 1'b0, 17'd10);
    found = 1'b0;
    for (int c = 0; c < 12 * BP && !found; c++) begin
      if (iteration_number == 17'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("t4.reach5", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 5; k++) m = ref_step(m, 17'h1D258);
    chk("t4.active", tx_active, 0);
    chk("t4.tx", tx_out, 0);
    chk("t4.done", done, 0);
    chk("t4.iter", iteration_number, 5);
    chk("t4.value", value, m);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || tx_active) saw_done = 1'b1;
    end
    chk("t4.quiet", saw_done, 0);
    run_burst(17'($urandom), 1'b1, 4, 1'b0, "t4.restart");

    run_burst(17'h1F0F0, 1'b0, 3, 1'b1, "t5.poke");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    burst_length = 17'd5;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5.abst_active", tx_active, 0);
    chk("t5.abst_done", done, 0);
    @(negedge clk);
    chk("t5.abst_active2", tx_active, 0);

    launch(17'h1ABCD, 1'b0, 17'd5);
    repeat (20) @(negedge clk);
    chk("t5.mid_active", tx_active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rst_tx", tx_out, 0);
    chk("t5.rst_active", tx_active, 0);
    chk("t5.rst_value", value, 0);
    chk("t5.rst_iter", iteration_number, 0);
    chk("t5.rst_done", done, 0);
    chk("t5.rst_strobe", bit_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(17'($urandom), 1'b0, 2, 1'b0, "t5.recover");

    run_burst(17'($urandom), 1'($urandom), 1000, 1'b0, "t6a");
    run_burst(17'($urandom), 1'($urandom), 1000, 1'b0, "t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
